booth_seq_multiplier: RTL and testbench

//  Sequential radix-2 Booth multiplier, parametrised in operand width, with a selectable

---
 rtl/booth_seq_multiplier_if.sv | 24 ++
 rtl/booth_seq_multiplier.sv | 100 ++++++++++
 tb/tb_booth_seq_multiplier.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/booth_seq_multiplier_if.sv
// Operand/product valid-ready bus of the sequential Booth multiplier.
// master drives operands and accepts products; slave is the multiplier.
interface booth_seq_multiplier_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier, one Booth step per clock, signed/unsigned
// operands selected per transaction; valid/ready on both operand and product side.
module booth_seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    booth_seq_multiplier_if.slave   bus
);
    // One extra operand bit makes unsigned inputs look like positive signed ones.
    localparam int E  = WIDTH + 1;
    localparam int CW = $clog2(E + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [E:0]           acc;
    logic [E-1:0]         m_reg;
    logic [E-1:0]         q_reg;
    logic                 q_m1;
    logic [CW-1:0]        count;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [2*WIDTH-1:0]   product_r;

    logic [E:0]           m_ext;
    logic [E:0]           acc_nxt;
    logic [E:0]           acc_sh;
    logic [E-1:0]         q_sh;
    logic [2*WIDTH-1:0]   prod_nxt;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.product   = product_r;

    always_comb begin
        m_ext   = {m_reg[E-1], m_reg};
        acc_nxt = acc;
        case ({q_reg[0], q_m1})
            2'b01:   acc_nxt = acc + m_ext;
            2'b10:   acc_nxt = acc - m_ext;
            default: acc_nxt = acc;
        endcase
        // Arithmetic right shift of the {acc, Q, q_m1} chain.
        acc_sh   = {acc_nxt[E], acc_nxt[E:1]};
        q_sh     = {acc_nxt[0], q_reg[E-1:1]};
        prod_nxt = {acc_sh[WIDTH-2:0], q_sh};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            product_r   <= '0;
            acc         <= '0;
            m_reg       <= '0;
            q_reg       <= '0;
            q_m1        <= 1'b0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        m_reg      <= {bus.signed_mode & bus.a[WIDTH-1], bus.a};
                        q_reg      <= {bus.signed_mode & bus.b[WIDTH-1], bus.b};
                        q_m1       <= 1'b0;
                        acc        <= '0;
                        count      <= CW'(E);
                        in_ready_r <= 1'b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_sh;
                    q_reg <= q_sh;
                    q_m1  <= q_reg[0];
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        product_r   <= prod_nxt;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier: directed corner products, backpressure,
// mid-operation reset, a grid sweep and randomized traffic with operand churn.
module tb_booth_seq_multiplier;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    booth_seq_multiplier_if #(.WIDTH(W)) bus ();
    booth_seq_multiplier #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ready_mode = 1;   // 0: stall, 1: always ready, 2: random stalls
    logic [2*W-1:0] exp_q[$];
    int acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer multiply of the interpreted operands.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic m);
        longint x, y;
        logic [63:0] p;
        x = m ? longint'($signed(a)) : longint'({1'b0, a});
        y = m ? longint'($signed(b)) : longint'({1'b0, b});
        p = x * y;
        return p[2*W-1:0];
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input logic [2*W-1:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", 64'd0, 64'd1);
        bus.a = a;
        bus.b = b;
        bus.signed_mode = m;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        exp_q.push_back(exp);
        acc_q.push_back(cyc);
    endtask

    // Wait for IDLE; optionally churn operands and pulse in_valid while busy.
    task automatic wait_idle(input bit scramble);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (scramble && !bus.in_ready) begin
                bus.a = W'($urandom);
                bus.b = W'($urandom);
                bus.signed_mode = 1'($urandom);
                bus.in_valid = 1'($urandom);
            end
        end while (!bus.in_ready && n < 400);
        bus.in_valid = 1'b0;
        if (!bus.in_ready) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom);
            endcase
        end
    end

    initial begin
        logic prev_ov;
        int a0;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && !prev_ov) begin
                if (acc_q.size() == 0) chk("latency_no_accept", 64'd1, 64'd0);
                else begin
                    a0 = acc_q.pop_front();
                    chk("latency", 64'(cyc - a0), 64'(W + 1));
                end
            end
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_product", 64'd1, 64'd0);
                else chk("product", 64'(bus.product), 64'(exp_q.pop_front()));
            end
            prev_ov = bus.out_valid;
        end
    end

    initial begin
        logic [2*W-1:0] snap;
        logic [W-1:0] ra, rb;
        logic rm;
        int n;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.signed_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_product", 64'(bus.product), 64'd0);
        reset = 1'b0;

        // Directed corner products
        ready_mode = 1;
        send(16'd32767, 16'd32767, 1'b0, 32'd1073676289);
        send(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        send(16'h8000, 16'h8000, 1'b1, 32'h40000000);
        send(16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF);
        send(16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF);
        send(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
        wait_idle(1'b0);

        // Backpressure: product held, in_valid ignored
        ready_mode = 0;
        send(16'h8000, 16'h8000, 1'b1, 32'h40000000);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", 64'(bus.out_valid), 64'd1);
        snap = bus.product;
        repeat (10) begin
            bus.in_valid = 1'b1;
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            @(negedge clk);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_product_stable", 64'(bus.product), 64'(snap));
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        ready_mode = 1;
        send(16'd5, 16'd7, 1'b0, 32'd35);
        wait_idle(1'b0);

        // Reset in the middle of CALC
        send(16'd1234, 16'd5678, 1'b0, ref_mul(16'd1234, 16'd5678, 1'b0));
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        chk("midreset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midreset_product", 64'(bus.product), 64'd0);
        chk("midreset_in_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b0;
        send(16'hFFFE, 16'h0003, 1'b1, 32'hFFFFFFFA);
        wait_idle(1'b0);

        // Grid sweep, both modes, random output stalls
        ready_mode = 2;
        for (int m = 0; m < 2; m++)
            for (int ia = 0; ia <= 32767; ia += 2000)
                for (int ib = 0; ib <= 32767; ib += 2000)
                    send(W'(ia), W'(ib), 1'(m), ref_mul(W'(ia), W'(ib), 1'(m)));

        // Random traffic with operand churn while busy
        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rm = 1'($urandom);
            send(ra, rb, rm, ref_mul(ra, rb, rm));
            wait_idle(1'b1);
        end

        ready_mode = 1;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
